// File: rtl/sma_decimator_pkg.sv
// -----------------------------------------------------------------------------
// sma_decimator_pkg
// Shared definitions for the SMA decimator slice: default sample width, the
// largest supported decimation exponent, FIFO depth limits and small helpers
// used to size the accumulator and validate parameters at elaboration.
// No ports (package).
// -----------------------------------------------------------------------------
package sma_decimator_pkg;

  localparam int SMA_DATA_W       = 16;
  localparam int SMA_DEC_LOG2_MAX = 4;
  localparam int SMA_FIFO_MIN     = 2;
  localparam int SMA_FIFO_MAX     = 16;

  // A block of 2**dec_log2 samples needs dec_log2 guard bits above the sample.
  function automatic int acc_width(input int data_w, input int dec_log2);
    return data_w + dec_log2;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/sma_dec_fifo.sv
// -----------------------------------------------------------------------------
// sma_dec_fifo
// Synchronous FIFO, DATA_W x DEPTH, with a registered head word.
// The head register holds the oldest entry and keeps its last value once the
// FIFO drains, so the consumer-facing data never shows stale RAM contents.
// A push and a pop in the same cycle both take effect, also when full.
// Ports:
//   clk, rst (async, active-low)
//   push  in  : write din (ignored when full unless popping the same cycle)
//   pop   in  : remove head (ignored when empty)
//   din   in  : data to write
//   head  out : oldest entry (holds last value when empty)
//   full  out : DEPTH entries stored
//   empty out : no entries stored
// -----------------------------------------------------------------------------
module sma_dec_fifo
  import sma_decimator_pkg::*;
#(
  parameter int DATA_W = SMA_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!is_pow2(DEPTH) || (DEPTH < SMA_FIFO_MIN) || (DEPTH > SMA_FIFO_MAX)) begin : g_bad_depth
    $error("sma_dec_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] head_nxt_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign full_s    = (cnt_r == CNT_W'(DEPTH));
  assign empty_s   = (cnt_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop && !empty_s;
  // Full is no obstacle when the head leaves in the same cycle.
  assign push_ok_s = push && (!full_s || pop_ok_s);
  assign rd_next_s = rd_ptr_r + PTR_W'(1'b1);

  // Next head word: follows the entry behind the popped one, or the incoming
  // word when it lands in an empty (or just-emptied) FIFO.
  always_comb begin
    head_nxt_s = head_r;
    if (pop_ok_s) begin
      if (cnt_r == CNT_W'(1'b1)) begin
        if (push_ok_s) begin
          head_nxt_s = din;
        end else begin
          head_nxt_s = head_r;
        end
      end else begin
        head_nxt_s = mem_r[rd_next_s];
      end
    end else if (empty_s && push_ok_s) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array write port; contents need no reset since cnt_r gates reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy count and head register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      head_r   <= {DATA_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
      head_r <= head_nxt_s;
    end
  end

  assign head  = head_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/sma_decimator.sv
// -----------------------------------------------------------------------------
// sma_decimator
// Averages each non-overlapping block of 2**DEC_LOG2 signed samples from the
// upstream SMA filter and queues one result per block in an output FIFO.
// Build option: define SMA_DEC_ROUND_EN to round half up instead of flooring.
// Ports:
//   clk, rst (async, active-low)
//   in_data   in  : signed sample, valid when in_valid
//   in_valid  in  : new sample this cycle (no upstream backpressure)
//   out_data  out : signed block average, head of FIFO (qualify with out_valid)
//   out_valid out : FIFO not empty
//   out_ready in  : consumer takes out_data when out_valid && out_ready
//   overflow  out : sticky, a block result was dropped because the FIFO was full
//   clr_ovf   in  : synchronous clear of overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module sma_decimator
  import sma_decimator_pkg::*;
#(
  parameter int DATA_W     = SMA_DATA_W,
  parameter int DEC_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int ACC_W = acc_width(DATA_W, DEC_LOG2);

  if ((DEC_LOG2 < 32'sd1) || (DEC_LOG2 > SMA_DEC_LOG2_MAX)) begin : g_bad_dec
    $error("sma_decimator: DEC_LOG2 must be 1..4");
  end

  localparam logic [DEC_LOG2-1:0] PHASE_LAST = {DEC_LOG2{1'b1}};

`ifdef SMA_DEC_ROUND_EN
  // Half an LSB of the shifted result; the block sum has room for it because
  // 2**DEC_LOG2 full-scale samples leave at least 2**DEC_LOG2 - 1 of headroom.
  localparam logic signed [ACC_W-1:0] RND_INC = ACC_W'(1'b1) << (DEC_LOG2 - 1);
`endif

  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  sext_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0]        result_s;
  logic [DEC_LOG2-1:0]      phase_r;
  logic                     push_s;
  logic                     pop_s;
  logic                     drop_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     overflow_r;

  assign sext_s = {{DEC_LOG2{in_data[DATA_W-1]}}, in_data};
  assign sum_s  = acc_r + sext_s;

  // Block average; the shifted value always fits DATA_W so truncation is exact.
  always_comb begin
`ifdef SMA_DEC_ROUND_EN
    result_s = DATA_W'((sum_s + RND_INC) >>> DEC_LOG2);
`else
    result_s = DATA_W'(sum_s >>> DEC_LOG2);
`endif
  end

  assign push_s = in_valid && (phase_r == PHASE_LAST);
  assign pop_s  = out_ready && !empty_s;
  assign drop_s = push_s && full_s && !pop_s;

  // Block accumulator and phase; both hold through gaps in in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r   <= {ACC_W{1'b0}};
      phase_r <= {DEC_LOG2{1'b0}};
    end else if (in_valid) begin
      if (phase_r == {DEC_LOG2{1'b0}}) begin
        acc_r <= sext_s;
      end else begin
        acc_r <= sum_s;
      end
      // Power-of-two block length: the counter wraps to 0 on its own.
      phase_r <= phase_r + DEC_LOG2'(1'b1);
    end else begin
      acc_r   <= acc_r;
      phase_r <= phase_r;
    end
  end

  // Sticky drop flag; a drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sma_dec_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (result_s),
    .head  (out_data),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = !empty_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_sma_decimator.sv
// -----------------------------------------------------------------------------
// tb_sma_decimator
// Self-checking bench for sma_decimator (default parameters). A reference model
// gathers samples into blocks, averages them with integer arithmetic, tracks
// the expected FIFO occupancy and overflow flag, and queues expected results.
// A monitor compares every output handshake and the idle state against it.
// -----------------------------------------------------------------------------
module tb_sma_decimator;

  localparam int DATA_W = 16;
  localparam int D      = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  int exp_q[$];
  int blk[$];
  int model_cnt = 0;
  bit exp_ovf = 1'b0;
  int last_acc = 0;

  always #5 clk = ~clk;

  sma_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  function automatic int floordiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int block_avg(input int s);
`ifdef SMA_DEC_ROUND_EN
    return floordiv(s + D / 2, D);
`else
    return floordiv(s, D);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at every active edge with the inputs of that cycle.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      blk.delete();
      exp_q.delete();
      model_cnt = 0;
      exp_ovf   = 1'b0;
      last_acc  = 0;
    end else begin
      bit pop_m;
      bit push_m;
      int val;
      int s;
      pop_m  = (model_cnt > 0) && out_ready;
      push_m = 1'b0;
      val    = 0;
      if (in_valid) begin
        blk.push_back(int'($signed(in_data)));
        if (blk.size() == D) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          val    = block_avg(s);
          push_m = 1'b1;
          blk.delete();
        end
      end
      if (push_m && model_cnt == DEPTH && !pop_m) begin
        exp_ovf = 1'b1;
      end else begin
        if (clr_ovf) exp_ovf = 1'b0;
        if (push_m) begin
          exp_q.push_back(val);
          last_acc = val;
          model_cnt++;
        end
      end
      if (pop_m) model_cnt--;
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("out_valid", int'(out_valid), int'(model_cnt > 0));
      check("overflow", int'(overflow), int'(exp_ovf));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none at %0t",
                   $signed(out_data), $time);
        end else begin
          check("out_data", int'($signed(out_data)), exp_q.pop_front());
        end
      end else if (!out_valid) begin
        check("hold_data", int'($signed(out_data)), last_acc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v);
    in_data  = DATA_W'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int v);
    for (int i = 0; i < D; i++) send(v);
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (model_cnt > 0 && k < 200) begin
      idle(1);
      k++;
    end
    idle(2);
    check("drain_done", model_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'($signed(out_data)), 0);
    check("reset_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;

    // Plain averaging
    out_ready = 1'b1;
    send(10); send(20); send(30); send(41);
    idle(3);

    // Negatives and full-scale blocks
    send(-1); send(-1); send(-1); send(-2);
    send_block(-32768);
    send_block(32767);
    idle(3);

    // Gapped input inside one block
    send(8); send(8);
    idle(5);
    send(8); send(8);
    idle(3);

    // Backpressure: four held, fifth dropped
    out_ready = 1'b0;
    send_block(11); send_block(22); send_block(33); send_block(44); send_block(55);
    idle(2);
    @(negedge clk);
    check("ovf_set", int'(overflow), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(8);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", int'(overflow), 0);
    @(posedge clk);
    #1;

    // Full FIFO with push and pop on the same edge
    out_ready = 1'b0;
    send_block(1); send_block(2); send_block(3); send_block(4);
    send(7); send(7); send(7);
    out_ready = 1'b1;
    send(7);
    idle(8);
    @(negedge clk);
    check("full_pushpop_ovf", int'(overflow), 0);
    @(posedge clk);
    #1;

    // Random traffic, light then heavy backpressure
    for (int c = 0; c < 700; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom_range(0, 65535));
      out_ready = (c < 400) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    drain();

    // Reset mid-run with FIFO full, overflow set and a partial block
    out_ready = 1'b0;
    send_block(50); send_block(50); send_block(50); send_block(50); send_block(50);
    send(60); send(60);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_ovf", int'(overflow), 0);
    check("midrst_data", int'($signed(out_data)), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send_block(100);
    idle(3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
